// File: rtl/cpu_slot_arbiter.sv
// Time-slot arbiter sharing one device bus among NCPU cores on a single clock.
// Optional device wait-state stretching is enabled with `define ARB_WAIT_EN.
module cpu_slot_arbiter #(
  parameter int NCPU     = 3,
  parameter int NSLOT    = 4,
  parameter int SLOT_LEN = 4,
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  input  logic [NCPU-1:0]      PAUSE,
  output logic [NCPU-1:0]      CPU_CE,
  input  logic [NCPU*AW-1:0]   CPU_AD,
  input  logic [NCPU-1:0]      CPU_RD,
  input  logic [NCPU-1:0]      CPU_WR,
  input  logic [NCPU*DW-1:0]   CPU_DO,
  output logic [NCPU*DW-1:0]   CPU_DI,
  output logic [NCPU-1:0]      CPU_DV,
  output logic [NCPU-1:0]      DEV_SEL,
  output logic [AW-1:0]        DEV_AD,
  output logic                 DEV_RD,
  output logic                 DEV_WR,
  output logic [DW-1:0]        DEV_DI,
  output logic                 DEV_CE,
  input  logic                 DEV_DV,
  input  logic [DW-1:0]        DEV_DO,
  input  logic                 DEV_RDY
);
  localparam int PHW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int SLW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic [PHW-1:0]     r_ph;
  logic [SLW-1:0]     r_sl;
  logic [NCPU-1:0]    r_ce;
  logic [NCPU*DW-1:0] r_di;
  logic [NCPU-1:0]    r_dv;

  logic [NCPU-1:0] w_sel;
  logic [AW-1:0]   w_ad;
  logic [DW-1:0]   w_di;
  logic            w_rd, w_wr, w_pause, w_own_vld, w_last, w_act;
  logic            w_stall, w_force, w_commit;

  // Owner decode: idle slots (sl >= NCPU) leave everything at zero.
  always_comb begin
    w_sel   = '0;
    w_ad    = '0;
    w_di    = '0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_pause = 1'b0;
    for (int i = 0; i < NCPU; i++) begin
      if (r_sl == SLW'(i)) begin
        w_sel[i] = 1'b1;
        w_ad     = CPU_AD[i*AW +: AW];
        w_di     = CPU_DO[i*DW +: DW];
        w_rd     = CPU_RD[i];
        w_wr     = CPU_WR[i];
        w_pause  = PAUSE[i];
      end
    end
  end

  assign w_own_vld = |w_sel;
  assign w_last    = (r_ph == PHW'(SLOT_LEN-1));
  assign w_act     = w_own_vld & ~w_pause;

`ifdef ARB_WAIT_EN
  localparam int SCW = $clog2(WAIT_MAX+1);
  logic [SCW-1:0] r_stall;
  logic           w_wait;

  // A stalled commit holds ph; once WAIT_MAX stalls accrue the slot is force-closed.
  assign w_wait  = w_last & w_act & (w_rd | w_wr) & ~DEV_RDY;
  assign w_stall = w_wait & (r_stall != SCW'(WAIT_MAX));
  assign w_force = w_wait & ~w_stall;

  always_ff @(posedge MCLK) begin
    if (RESET)        r_stall <= '0;
    else if (w_stall) r_stall <= r_stall + 1'b1;
    else if (w_last)  r_stall <= '0;
  end
`else
  logic [1:0] w_unused;
  assign w_unused = {DEV_RDY, WAIT_MAX[0]};
  assign w_stall  = 1'b0;
  assign w_force  = 1'b0;
`endif

  assign w_commit = w_last & w_act & ~w_stall;

  assign DEV_SEL = w_sel;
  assign DEV_AD  = w_ad;
  assign DEV_DI  = w_di;
  assign DEV_RD  = w_rd & w_act;
  assign DEV_WR  = w_wr & w_act;
  assign DEV_CE  = w_commit & ~w_force;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_ph <= '0;
      r_sl <= '0;
      r_ce <= '0;
      r_di <= '0;
      r_dv <= '0;
    end else begin
      if (!w_stall) begin
        if (w_last) begin
          r_ph <= '0;
          r_sl <= (r_sl == SLW'(NSLOT-1)) ? '0 : r_sl + 1'b1;
        end else begin
          r_ph <= r_ph + 1'b1;
        end
      end
      r_ce <= w_commit ? w_sel : '0;
      for (int i = 0; i < NCPU; i++) begin
        if (w_commit && w_sel[i]) begin
          if (!w_force) r_di[i*DW +: DW] <= DEV_DO;
          r_dv[i] <= DEV_DV & CPU_RD[i] & ~w_force;
        end
      end
    end
  end

  assign CPU_CE = r_ce;
  assign CPU_DI = r_di;
  assign CPU_DV = r_dv;
endmodule

// File: tb/tb_cpu_slot_arbiter.sv
// Directed bench for cpu_slot_arbiter: slot-level vector table plus reset and wait-state sequences.
module tb_cpu_slot_arbiter;
  localparam int SL = 4;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [2:0]  PAUSE, CPU_RD, CPU_WR;
  logic [2:0]  CPU_CE, CPU_DV, DEV_SEL;
  logic [47:0] CPU_AD;
  logic [23:0] CPU_DO, CPU_DI;
  logic [15:0] DEV_AD;
  logic [7:0]  DEV_DI, DEV_DO;
  logic        DEV_RD, DEV_WR, DEV_CE, DEV_DV, DEV_RDY;

  cpu_slot_arbiter dut (
    .MCLK(MCLK), .RESET(RESET), .PAUSE(PAUSE), .CPU_CE(CPU_CE),
    .CPU_AD(CPU_AD), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_DO(CPU_DO),
    .CPU_DI(CPU_DI), .CPU_DV(CPU_DV), .DEV_SEL(DEV_SEL), .DEV_AD(DEV_AD),
    .DEV_RD(DEV_RD), .DEV_WR(DEV_WR), .DEV_DI(DEV_DI), .DEV_CE(DEV_CE),
    .DEV_DV(DEV_DV), .DEV_DO(DEV_DO), .DEV_RDY(DEV_RDY)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [2:0]  pause, rd, wr;
    logic [7:0]  ddo;
    logic        ddv;
    logic [2:0]  ce, sel;
    logic        drd, dwr;
    logic [15:0] dad;
    logic [7:0]  ddi;
    logic        dce;
    logic [23:0] cdi;
    logic [2:0]  cdv;
  } slot_t;

  slot_t tbl[18];
  int tests = 0;
  int fails = 0;

  function automatic slot_t mk(logic [2:0] pause, logic [2:0] rd, logic [2:0] wr,
                               logic [7:0] ddo, logic ddv, logic [2:0] ce, logic [2:0] sel,
                               logic drd, logic dwr, logic [15:0] dad, logic [7:0] ddi,
                               logic dce, logic [23:0] cdi, logic [2:0] cdv);
    slot_t s;
    s.pause = pause; s.rd = rd; s.wr = wr; s.ddo = ddo; s.ddv = ddv;
    s.ce = ce; s.sel = sel; s.drd = drd; s.dwr = dwr; s.dad = dad;
    s.ddi = ddi; s.dce = dce; s.cdi = cdi; s.cdv = cdv;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    CPU_AD  = {16'h2222, 16'h6800, 16'h1111};
    CPU_DO  = {8'h3C, 8'h22, 8'h11};
    PAUSE = '0; CPU_RD = '0; CPU_WR = '0;
    DEV_DO = '0; DEV_DV = 1'b0; DEV_RDY = 1'b1;

    //              pause  rd     wr     do     dv  | ce     sel   rd wr  ad        di     ce  cdi         cdv
    tbl[0]  = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b000,3'b001,0,0,16'h1111,8'h11,1,24'h000000,3'b000);
    tbl[1]  = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b001,3'b010,0,0,16'h6800,8'h22,1,24'h000000,3'b000);
    tbl[2]  = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b010,3'b100,0,0,16'h2222,8'h3C,1,24'h000000,3'b000);
    tbl[3]  = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b100,3'b000,0,0,16'h0000,8'h00,0,24'h000000,3'b000);
    tbl[4]  = mk(3'b000,3'b010,3'b000,8'h00,1'b0, 3'b000,3'b001,0,0,16'h1111,8'h11,1,24'h000000,3'b000);
    tbl[5]  = mk(3'b000,3'b010,3'b000,8'hA5,1'b1, 3'b001,3'b010,1,0,16'h6800,8'h22,1,24'h000000,3'b000);
    tbl[6]  = mk(3'b000,3'b000,3'b100,8'h00,1'b0, 3'b010,3'b100,0,1,16'h2222,8'h3C,1,24'h00A500,3'b010);
    tbl[7]  = mk(3'b000,3'b000,3'b000,8'h5A,1'b1, 3'b100,3'b000,0,0,16'h0000,8'h00,0,24'h00A500,3'b010);
    tbl[8]  = mk(3'b001,3'b001,3'b001,8'h77,1'b1, 3'b000,3'b001,0,0,16'h1111,8'h11,0,24'h00A500,3'b010);
    tbl[9]  = mk(3'b001,3'b010,3'b000,8'hC3,1'b1, 3'b000,3'b010,1,0,16'h6800,8'h22,1,24'h00A500,3'b010);
    tbl[10] = mk(3'b001,3'b000,3'b000,8'h00,1'b0, 3'b010,3'b100,0,0,16'h2222,8'h3C,1,24'h00C300,3'b010);
    tbl[11] = mk(3'b001,3'b000,3'b000,8'h00,1'b0, 3'b100,3'b000,0,0,16'h0000,8'h00,0,24'h00C300,3'b010);
    tbl[12] = mk(3'b001,3'b001,3'b000,8'h77,1'b1, 3'b000,3'b001,0,0,16'h1111,8'h11,0,24'h00C300,3'b010);
    tbl[13] = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b000,3'b010,0,0,16'h6800,8'h22,1,24'h00C300,3'b010);
    tbl[14] = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b010,3'b100,0,0,16'h2222,8'h3C,1,24'h000000,3'b000);
    tbl[15] = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b100,3'b000,0,0,16'h0000,8'h00,0,24'h000000,3'b000);
    tbl[16] = mk(3'b000,3'b001,3'b000,8'h99,1'b1, 3'b000,3'b001,1,0,16'h1111,8'h11,1,24'h000000,3'b000);
    tbl[17] = mk(3'b000,3'b000,3'b000,8'h00,1'b0, 3'b001,3'b010,0,0,16'h6800,8'h22,1,24'h000099,3'b001);

    RESET = 1'b1;
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b0;

    // Inputs are held for a whole slot; CE appears only at ph0, DEV_CE only at the last phase.
    for (int s = 0; s < 18; s++) begin
      for (int p = 0; p < SL; p++) begin
        PAUSE = tbl[s].pause; CPU_RD = tbl[s].rd; CPU_WR = tbl[s].wr;
        DEV_DO = tbl[s].ddo; DEV_DV = tbl[s].ddv;
        #1;
        chk($sformatf("s%0d.p%0d CPU_CE", s, p), 32'(CPU_CE), 32'((p == 0) ? tbl[s].ce : 3'b000));
        chk($sformatf("s%0d.p%0d DEV_SEL", s, p), 32'(DEV_SEL), 32'(tbl[s].sel));
        chk($sformatf("s%0d.p%0d DEV_RD", s, p), 32'(DEV_RD), 32'(tbl[s].drd));
        chk($sformatf("s%0d.p%0d DEV_WR", s, p), 32'(DEV_WR), 32'(tbl[s].dwr));
        chk($sformatf("s%0d.p%0d DEV_AD", s, p), 32'(DEV_AD), 32'(tbl[s].dad));
        chk($sformatf("s%0d.p%0d DEV_DI", s, p), 32'(DEV_DI), 32'(tbl[s].ddi));
        chk($sformatf("s%0d.p%0d DEV_CE", s, p), 32'(DEV_CE), 32'((p == SL-1) ? tbl[s].dce : 1'b0));
        chk($sformatf("s%0d.p%0d CPU_DI", s, p), 32'(CPU_DI), 32'(tbl[s].cdi));
        chk($sformatf("s%0d.p%0d CPU_DV", s, p), 32'(CPU_DV), 32'(tbl[s].cdv));
        @(negedge MCLK);
      end
    end

    // Reset at ph2 of slot 1 while channel 1 reads: no capture, counters back to 0.
    PAUSE = '0; CPU_RD = 3'b010; CPU_WR = '0; DEV_DO = 8'hEE; DEV_DV = 1'b1;
    n = 0;
    #1;
    while (DEV_SEL !== 3'b010 && n < 32) begin
      @(negedge MCLK); #1; n++;
    end
    chk("reach slot1", 32'(DEV_SEL), 32'(3'b010));
    @(negedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    @(negedge MCLK);
    #1;
    chk("rst DEV_SEL", 32'(DEV_SEL), 32'(3'b001));
    chk("rst CPU_CE", 32'(CPU_CE), 32'(3'b000));
    chk("rst CPU_DV", 32'(CPU_DV), 32'(3'b000));
    chk("rst CPU_DI", 32'(CPU_DI), 32'(24'h000000));
    RESET = 1'b0; CPU_RD = '0; DEV_DO = 8'h00; DEV_DV = 1'b0;
    for (int p = 0; p < SL; p++) begin
      #1;
      chk($sformatf("post-rst p%0d DEV_CE", p), 32'(DEV_CE), 32'(p == SL-1));
      chk($sformatf("post-rst p%0d CPU_CE", p), 32'(CPU_CE), 32'(3'b000));
      @(negedge MCLK);
    end
    #1;
    chk("post-rst CE0", 32'(CPU_CE), 32'(3'b001));

`ifdef ARB_WAIT_EN
    // Three wait cycles during a channel 0 read delay its CE by three cycles.
    RESET = 1'b1;
    @(negedge MCLK);
    RESET = 1'b0; CPU_RD = 3'b001; DEV_DO = 8'hAB; DEV_DV = 1'b1; DEV_RDY = 1'b1;
    repeat (3) @(negedge MCLK);
    DEV_RDY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wait%0d DEV_CE", k), 32'(DEV_CE), 32'(1'b0));
      chk($sformatf("wait%0d DEV_RD", k), 32'(DEV_RD), 32'(1'b1));
      @(negedge MCLK);
      chk($sformatf("wait%0d CPU_CE", k), 32'(CPU_CE), 32'(3'b000));
    end
    DEV_RDY = 1'b1;
    #1;
    chk("wait release DEV_CE", 32'(DEV_CE), 32'(1'b1));
    @(negedge MCLK);
    #1;
    chk("wait CE0", 32'(CPU_CE), 32'(3'b001));
    chk("wait CPU_DI", 32'(CPU_DI), 32'(24'h0000AB));
    chk("wait CPU_DV", 32'(CPU_DV), 32'(3'b001));
    // With the device never ready, slot 0 is force-closed after WAIT_MAX stalls.
    DEV_RDY = 1'b0; DEV_DO = 8'hCD;
    repeat (12) @(negedge MCLK);
    #1;
    chk("force slot0", 32'(DEV_SEL), 32'(3'b001));
    n = 0;
    while (CPU_CE[0] !== 1'b1 && n < 40) begin
      @(negedge MCLK); #1; n++;
    end
    chk("force CE delay", 32'(n), 32'(19));
    chk("force CPU_DV", 32'(CPU_DV), 32'(3'b000));
    chk("force CPU_DI", 32'(CPU_DI), 32'(24'h0000AB));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
